// File: rtl/divu_pkg.sv
// divu_pkg: constants and types shared by the sequential unsigned divider.
//   DIVU_WIDTH   default operand/result width
//   divu_state_e controller states (IDLE, RUN, DONE)
//   divu_cnt_w() iteration counter width for a given operand width
//   DIVU_CNT_W   iteration counter width at the default width
package divu_pkg;

  localparam int DIVU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } divu_state_e;

  // ceil(log2(w)) + 1 bits, so the counter can hold w-1 without wrapping.
  function automatic int divu_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int DIVU_CNT_W = $clog2(DIVU_WIDTH) + 1;

endpackage

// File: rtl/divu_sub.sv
// divu_sub: purely combinational W-bit subtractor, out = in0 - in1 (mod 2^W).
//   in0  minuend
//   in1  subtrahend
//   out  difference; the MSB acts as the borrow/sign flag for the divider
module divu_sub #(
  parameter int W = 33
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);

  assign out = in0 - in1;

endmodule

// File: rtl/divu_seq.sv
// divu_seq: multi-cycle restoring unsigned divider, one quotient bit per clock.
//   clk          clock, all state changes on rising edge
//   reset        synchronous active-high reset
//   start        request a divide; only taken while idle
//   in0, in1     dividend and divisor, sampled on the accepting edge
//   quotient     registered in0 / in1 (all ones on divide by zero)
//   remainder    registered in0 % in1 (in0 on divide by zero)
//   busy         high whenever the controller is not idle
//   done         one-cycle pulse when quotient/remainder are updated
//   div_by_zero  set alongside done for a zero divisor, held until next accept
module divu_seq
  import divu_pkg::*;
#(
  parameter int WIDTH = DIVU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = divu_cnt_w(WIDTH);

  divu_state_e      state_reg;
  logic [WIDTH-1:0] dvd_reg;    // dividend, shifts out MSB-first; quotient bits shift in at LSB
  logic [WIDTH-1:0] dvsr_reg;
  logic [WIDTH-1:0] rem_reg;    // restored partial remainder, always < divisor
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] quo_out_reg;
  logic [WIDTH-1:0] rem_out_reg;
  logic             done_reg;
  logic             dbz_reg;

  // One restoring step: form the WIDTH+1-bit shifted partial remainder,
  // subtract the zero-extended divisor, and use the borrow bit to decide.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] step_rem;

  assign shifted = {rem_reg, dvd_reg[WIDTH-1]};

  divu_sub #(.W(WIDTH + 1)) sub (
    .in0 (shifted),
    .in1 ({1'b0, dvsr_reg}),
    .out (diff)
  );

  assign q_bit    = ~diff[WIDTH];
  assign step_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      dvd_reg     <= '0;
      dvsr_reg    <= '0;
      rem_reg     <= '0;
      cnt_reg     <= '0;
      quo_out_reg <= '0;
      rem_out_reg <= '0;
      done_reg    <= 1'b0;
      dbz_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            dvd_reg  <= in0;
            dvsr_reg <= in1;
            rem_reg  <= '0;
            cnt_reg  <= '0;
            dbz_reg  <= 1'b0;
            if (in1 == '0) begin
              // Zero divisor skips the iteration entirely.
              quo_out_reg <= '1;
              rem_out_reg <= in0;
              dbz_reg     <= 1'b1;
              done_reg    <= 1'b1;
              state_reg   <= ST_DONE;
            end else begin
              state_reg <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          rem_reg <= step_rem;
          dvd_reg <= {dvd_reg[WIDTH-2:0], q_bit};
          if (cnt_reg == CW'(WIDTH - 1)) begin
            // Last step: publish results; counter stops here, never wraps.
            quo_out_reg <= {dvd_reg[WIDTH-2:0], q_bit};
            rem_out_reg <= step_rem;
            done_reg    <= 1'b1;
            state_reg   <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign quotient    = quo_out_reg;
  assign remainder   = rem_out_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign done        = done_reg;
  assign div_by_zero = dbz_reg;

endmodule
